note_grid_renderer: RTL and testbench
=====================================

// Module: note_grid_renderer
// PURPOSE
// Parametrised successor to the fixed 3x4 note-box datapath. Streams song columns from an external
// song ROM into a per-lane scrolling note window, then rasterises every box of the grid to the VGA
// plot port: note boxes use a sprite ROM, empty boxes use the background colour. Sits between the
// game FSM (start/restart) and the VGA adapter. Exports the strike-column notes for scoring.
// PARAMETERS
// LANES     3    note lanes (grid rows), 1..8
// BOXES     4    visible boxes per lane (grid columns), 2..8
// SONG_LEN  115  song columns in song ROM
// BOX_W     30   box width, pixels
// BOX_H     60   box height, pixels
// ORIGIN_X  0    grid top-left X
// ORIGIN_Y  60   grid top-left Y
// BG_COL    3'b111  empty-box colour
// PORTS
// clock         in   1          single system clock
// reset         in   1          synchronous, active-high
// start         in   1          frame tick: advance song one column and redraw grid
// restart       in   1          rewind song, clear window, abort any frame
// songAddr      out  clog2(SONG_LEN)  song ROM address (1-cycle read latency)
// songData      in   LANES      note bits of one column, bit i = lane i
// spriteAddr    out  clog2(BOX_W*BOX_H) sprite ROM address = py*BOX_W+px (1-cycle latency)
// spriteData    in   3          sprite colour
// vgaX          out  9          plot X
// vgaY          out  8          plot Y
// vgaColour     out  3          plot colour
// plot          out  1          pixel valid; held with X/Y/colour stable until plotReady
// plotReady     in   1          VGA accepts pixel on plot&&plotReady
// busy          out  1          high from start acceptance to frameDone
// frameDone     out  1          1-cycle pulse after last pixel accepted
// songDone      out  1          sticky: song fully scrolled out
// strikeNotes   out  LANES      window[lane][BOXES-1] for each lane
// BEHAVIOUR
// - Reset: all outputs 0, window all 0, step counter 0, FSM IDLE.
// - FSM: IDLE -> FETCH -> LOAD -> DRAW -> DONE -> IDLE.
// - IDLE: start && !songDone -> FETCH. start while busy or songDone: ignored.
// - FETCH: songAddr = step (if step < SONG_LEN). LOAD: shift each lane's window one column toward
//   BOXES-1; col 0 <= songData[lane] if step < SONG_LEN else 0; step++.
// - songDone set in LOAD when step becomes SONG_LEN+BOXES; that frame still drawn (all empty).
// - DRAW order: lane 0..LANES-1 outer, col 0..BOXES-1, py 0..BOX_H-1, px 0..BOX_W-1 inner.
// - vgaX = ORIGIN_X + col*BOX_W + px; vgaY = ORIGIN_Y + lane*BOX_H + py; truncate to 9/8 bits.
// - 2-stage pipe: stage0 counters drive spriteAddr; stage1 registers X/Y, colour =
//   window bit ? spriteData : BG_COL, asserts plot. Counters and stage1 advance only when
//   !plot || plotReady; spriteAddr held during stall so spriteData stays valid.
// - Latency: with plotReady=1, first plot 4 clocks after start-sampling edge; one pixel/clock.
// - DONE: entered when last pixel accepted; frameDone=1 for one cycle; busy drops same cycle.
// - restart (priority over start, any state): next cycle plot=0, busy=0, window=0, step=0,
//   songDone=0, FSM IDLE; no frameDone. reset behaves identically plus clears outputs.
// - strikeNotes updates in LOAD only; stable during DRAW.
// STRUCTURE
// - note_grid_defs.vh: FSM state encodings, colour constants (BG white, black), clog2 macro.
// - Sub-module note_window: LANES x BOXES shift-register array (shift, clear, din[LANES],
//   cell read by lane/col, strike column out). Remainder (FSM, raster counters, pipe) in top.
// TESTING
// - Reset: assert reset 2 cycles -> plot=0, busy=0, songDone=0, strikeNotes=0, vgaX/Y/Colour=0.
// - Defaults, songData[0]=3'b001, plotReady=1, start -> first plot at (0,60) colour=spriteData,
//   exactly 21600 plots, box lane1 col0 pixel (0,120) colour 3'b111, one frameDone.
// - Scroll: columns 001,010,100,000 over 4 starts -> strikeNotes=3'b001 after 4th LOAD, 010 after 5th.
// - Backpressure: plotReady toggled 1/0 random -> still 21600 unique accepted pixels, in raster
//   order, X/Y/colour never change while plot&&!plotReady.
// - Song end: SONG_LEN=2, BOXES=4 -> songDone rises in 6th frame's LOAD; 7th start ignored (busy=0).
// - restart at pixel 5000 -> plot=0 next cycle, no frameDone, next start reads songAddr=0.

Source files
------------

// File: rtl/note_grid_renderer_pkg.sv
// Shared types and helpers for the note grid renderer: FSM state encoding,
// colour constants and a width helper that never returns zero.
package note_grid_renderer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] COL_WHITE = 3'b111;

    // Bit width needed to index n items, at least one bit.
    function automatic int width_of(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/note_grid_renderer_window.sv
// Per-lane scrolling note window: LANES x BOXES shift registers. Column 0
// receives the new song column; notes move toward column BOXES-1 (strike).
module note_grid_renderer_window #(
    parameter int LANES = 3,
    parameter int BOXES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic [LANES-1:0] din,
    input  logic [2:0]       rdLane,
    input  logic [2:0]       rdCol,
    output logic             rdBit,
    output logic [LANES-1:0] strike
);

    logic [LANES-1:0][BOXES-1:0] cells_r;
    logic                        rd_bit_s;
    logic [LANES-1:0]            strike_s;

    // Window storage: cleared on reset/restart, shifted once per song step.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cells_r <= '0;
        end else if (shift) begin
            for (int l = 0; l < LANES; l++) begin
                cells_r[l] <= {cells_r[l][BOXES-2:0], din[l]};
            end
        end
    end

    // Cell read for the rasteriser and strike-column extraction.
    always_comb begin
        rd_bit_s = 1'b0;
        strike_s = '0;
        for (int l = 0; l < LANES; l++) begin
            strike_s[l] = cells_r[l][BOXES-1];
            for (int c = 0; c < BOXES; c++) begin
                rd_bit_s = rd_bit_s |
                           ((3'(l) == rdLane) && (3'(c) == rdCol) && cells_r[l][c]);
            end
        end
    end

    assign rdBit  = rd_bit_s;
    assign strike = strike_s;

endmodule

// File: rtl/note_grid_renderer.sv
// Note grid renderer: steps the song one column per frame tick, then
// rasterises every box of the LANES x BOXES grid to the VGA plot port.
module note_grid_renderer
    import note_grid_renderer_pkg::*;
#(
    parameter int         LANES    = 3,
    parameter int         BOXES    = 4,
    parameter int         SONG_LEN = 115,
    parameter int         BOX_W    = 30,
    parameter int         BOX_H    = 60,
    parameter int         ORIGIN_X = 0,
    parameter int         ORIGIN_Y = 60,
    parameter logic [2:0] BG_COL   = COL_WHITE
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                restart,
    output logic [width_of(SONG_LEN)-1:0]       songAddr,
    input  logic [LANES-1:0]                    songData,
    output logic [width_of(BOX_W*BOX_H)-1:0]    spriteAddr,
    input  logic [2:0]                          spriteData,
    output logic [8:0]                          vgaX,
    output logic [7:0]                          vgaY,
    output logic [2:0]                          vgaColour,
    output logic                                plot,
    input  logic                                plotReady,
    output logic                                busy,
    output logic                                frameDone,
    output logic                                songDone,
    output logic [LANES-1:0]                    strikeNotes
);

    localparam int          SAW        = width_of(SONG_LEN);
    localparam int          SPW        = width_of(BOX_W * BOX_H);
    localparam int          PXW        = width_of(BOX_W);
    localparam int          PYW        = width_of(BOX_H);
    localparam logic [15:0] SONG_LEN_W = 16'(SONG_LEN);
    localparam logic [15:0] END_STEP   = 16'(SONG_LEN + BOXES);

    state_t           state_r, state_next_s;
    logic [15:0]      step_r, step_inc_s;
    logic [SAW-1:0]   song_addr_r;
    logic             song_done_r, busy_r, frame_done_r;
    logic             load_s, adv_s, last_pix_s;
    logic             px_wrap_s, py_wrap_s, col_wrap_s, lane_wrap_s;
    logic [LANES-1:0] window_din_s, strike_s;
    logic             cell_bit_s;
    logic [8:0]       x_s;
    logic [7:0]       y_s;
    // stage 0: raster counters (drive the sprite ROM address)
    logic [PXW-1:0]   px_r;
    logic [PYW-1:0]   py_r;
    logic [2:0]       col_r, lane_r;
    logic [SPW-1:0]   sprite_addr_r;
    logic             s0_valid_r;
    // middle: pixel metadata waiting for the sprite ROM read
    logic [8:0]       mid_x_r;
    logic [7:0]       mid_y_r;
    logic             mid_bit_r, mid_last_r, mid_valid_r, mid_fresh_r;
    logic [2:0]       mid_data_r, sprite_colour_s;
    // stage 1: registered plot outputs
    logic [8:0]       out_x_r;
    logic [7:0]       out_y_r;
    logic [2:0]       out_colour_r;
    logic             plot_r, out_last_r;

    assign load_s     = (state_r == ST_LOAD) && !restart;
    assign adv_s      = !plot_r || plotReady;
    assign step_inc_s = step_r + 16'd1;

    // Next-state logic; restart overrides everything and returns to idle.
    always_comb begin
        state_next_s = state_r;
        if (restart) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !song_done_r) state_next_s = ST_FETCH;
                    else                       state_next_s = ST_IDLE;
                end
                ST_FETCH: state_next_s = ST_LOAD;
                ST_LOAD:  state_next_s = ST_DRAW;
                ST_DRAW: begin
                    if (plot_r && plotReady && out_last_r) state_next_s = ST_DONE;
                    else                                   state_next_s = ST_DRAW;
                end
                ST_DONE:  state_next_s = ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Registered busy/frameDone decoded from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            busy_r       <= (state_next_s == ST_FETCH) || (state_next_s == ST_LOAD) ||
                            (state_next_s == ST_DRAW);
            frame_done_r <= (state_next_s == ST_DONE);
        end
    end

    // Song step counter, ROM address and sticky end-of-song flag.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            step_r      <= 16'd0;
            song_addr_r <= '0;
            song_done_r <= 1'b0;
        end else if (load_s) begin
            step_r <= step_inc_s;
            if (step_inc_s < SONG_LEN_W) song_addr_r <= SAW'(step_inc_s);
            else                         song_addr_r <= '0;
            if (step_inc_s == END_STEP)  song_done_r <= 1'b1;
        end
    end

    // New window column: song data while the song lasts, then empty columns.
    always_comb begin
        if (step_r < SONG_LEN_W) window_din_s = songData;
        else                     window_din_s = '0;
    end

    note_grid_renderer_window #(
        .LANES (LANES),
        .BOXES (BOXES)
    ) u_window (
        .clock  (clock),
        .reset  (reset),
        .clear  (restart),
        .shift  (load_s),
        .din    (window_din_s),
        .rdLane (lane_r),
        .rdCol  (col_r),
        .rdBit  (cell_bit_s),
        .strike (strike_s)
    );

    // Raster position decode; coordinates wrap naturally to 9/8 bits.
    always_comb begin
        px_wrap_s   = (px_r == PXW'(BOX_W - 1));
        py_wrap_s   = (py_r == PYW'(BOX_H - 1));
        col_wrap_s  = (col_r == 3'(BOXES - 1));
        lane_wrap_s = (lane_r == 3'(LANES - 1));
        last_pix_s  = px_wrap_s && py_wrap_s && col_wrap_s && lane_wrap_s;
        x_s = 9'(ORIGIN_X) + 9'(col_r) * 9'(BOX_W) + 9'(px_r);
        y_s = 8'(ORIGIN_Y) + 8'(lane_r) * 8'(BOX_H) + 8'(py_r);
    end

    // Stage 0 raster counters; the sprite address follows py*BOX_W+px linearly.
    always_ff @(posedge clock) begin
        if (reset || restart || load_s) begin
            px_r          <= '0;
            py_r          <= '0;
            col_r         <= 3'd0;
            lane_r        <= 3'd0;
            sprite_addr_r <= '0;
            s0_valid_r    <= load_s;
        end else if (adv_s && s0_valid_r) begin
            if (last_pix_s) s0_valid_r <= 1'b0;
            if (px_wrap_s && py_wrap_s) sprite_addr_r <= '0;
            else                        sprite_addr_r <= sprite_addr_r + SPW'(1);
            if (px_wrap_s) begin
                px_r <= '0;
                if (py_wrap_s) begin
                    py_r <= '0;
                    if (col_wrap_s) begin
                        col_r  <= 3'd0;
                        lane_r <= lane_r + 3'd1;
                    end else begin
                        col_r <= col_r + 3'd1;
                    end
                end else begin
                    py_r <= py_r + PYW'(1);
                end
            end else begin
                px_r <= px_r + PXW'(1);
            end
        end
    end

    // Sprite data is fresh only the cycle after the middle stage loads; a
    // stall captures it so the held address can move on without losing it.
    always_comb begin
        if (mid_fresh_r) sprite_colour_s = spriteData;
        else             sprite_colour_s = mid_data_r;
    end

    // Middle and output pipeline registers, advancing only when not stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            mid_x_r      <= 9'd0;
            mid_y_r      <= 8'd0;
            mid_bit_r    <= 1'b0;
            mid_last_r   <= 1'b0;
            mid_valid_r  <= 1'b0;
            mid_fresh_r  <= 1'b0;
            mid_data_r   <= 3'd0;
            out_x_r      <= 9'd0;
            out_y_r      <= 8'd0;
            out_colour_r <= 3'd0;
            out_last_r   <= 1'b0;
            plot_r       <= 1'b0;
        end else if (restart) begin
            mid_valid_r <= 1'b0;
            mid_fresh_r <= 1'b0;
            plot_r      <= 1'b0;
        end else begin
            mid_fresh_r <= adv_s;
            if (mid_fresh_r) mid_data_r <= spriteData;
            if (adv_s) begin
                mid_valid_r  <= s0_valid_r;
                mid_x_r      <= x_s;
                mid_y_r      <= y_s;
                mid_bit_r    <= cell_bit_s;
                mid_last_r   <= last_pix_s;
                plot_r       <= mid_valid_r;
                out_x_r      <= mid_x_r;
                out_y_r      <= mid_y_r;
                out_colour_r <= mid_bit_r ? sprite_colour_s : BG_COL;
                out_last_r   <= mid_last_r;
            end
        end
    end

    assign songAddr    = song_addr_r;
    assign spriteAddr  = sprite_addr_r;
    assign vgaX        = out_x_r;
    assign vgaY        = out_y_r;
    assign vgaColour   = out_colour_r;
    assign plot        = plot_r;
    assign busy        = busy_r;
    assign frameDone   = frame_done_r;
    assign songDone    = song_done_r;
    assign strikeNotes = strike_s;

endmodule

// File: tb/tb_note_grid_renderer.sv
// Scoreboard bench for note_grid_renderer: a full-size instance checks raster
// output, latency, backpressure and restart; a tiny instance checks scrolling
// and end of song.
module tb_note_grid_renderer;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic clock = 1'b0;
    logic reset, start, restart, plotReady, start2;
    logic [6:0]  songAddr;
    logic [2:0]  songData = 3'b000;
    logic [10:0] spriteAddr;
    logic [2:0]  spriteData = 3'b000;
    logic [8:0]  vgaX;
    logic [7:0]  vgaY;
    logic [2:0]  vgaColour, strikeNotes;
    logic        plot, busy, frameDone, songDone;

    logic [0:0]  songAddr2;
    logic [2:0]  songData2 = 3'b000;
    logic [2:0]  spriteAddr2;
    logic [2:0]  spriteData2 = 3'b000;
    logic [8:0]  vgaX2;
    logic [7:0]  vgaY2;
    logic [2:0]  vgaColour2, strikeNotes2;
    logic        plot2, busy2, frameDone2, songDone2;
    logic        plotReady2 = 1'b1;

    int   total = 0;
    int   bad = 0;
    int   acc_count = 0;
    int   fd_count = 0;
    logic bp_mode = 1'b0;
    pix_t exp_q[$];
    pix_t mon_e;
    logic        held_v = 1'b0;
    logic [19:0] held;
    logic [2:0]  colv [4];
    int          step_m;

    note_grid_renderer u_dut (
        .clock(clock), .reset(reset), .start(start), .restart(restart),
        .songAddr(songAddr), .songData(songData), .spriteAddr(spriteAddr),
        .spriteData(spriteData), .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour),
        .plot(plot), .plotReady(plotReady), .busy(busy), .frameDone(frameDone),
        .songDone(songDone), .strikeNotes(strikeNotes)
    );

    note_grid_renderer #(
        .LANES(3), .BOXES(4), .SONG_LEN(2), .BOX_W(3), .BOX_H(2)
    ) u_small (
        .clock(clock), .reset(reset), .start(start2), .restart(1'b0),
        .songAddr(songAddr2), .songData(songData2), .spriteAddr(spriteAddr2),
        .spriteData(spriteData2), .vgaX(vgaX2), .vgaY(vgaY2), .vgaColour(vgaColour2),
        .plot(plot2), .plotReady(plotReady2), .busy(busy2), .frameDone(frameDone2),
        .songDone(songDone2), .strikeNotes(strikeNotes2)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [2:0] song_fn(input int a);
        case (a)
            0:       return 3'b001;
            1:       return 3'b110;
            2:       return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] spr_fn(input int a);
        logic [10:0] t;
        t = 11'(a);
        return t[2:0] ^ t[6:4] ^ 3'b010;
    endfunction

    // External song and sprite ROMs, one-cycle read latency.
    always @(posedge clock) begin
        songData    <= song_fn(int'(songAddr));
        spriteData  <= spr_fn(int'(spriteAddr));
        songData2   <= (songAddr2 == 1'b0) ? 3'b001 : 3'b010;
        spriteData2 <= spr_fn(int'(spriteAddr2));
    end

    // VGA acceptance: always ready, or random in backpressure mode.
    initial begin
        plotReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            plotReady = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted pixel, checks stall hold.
    always @(negedge clock) begin
        if (plot) begin
            if (held_v) begin
                total++;
                if ({vgaX, vgaY, vgaColour} !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got %h expected %h", {vgaX, vgaY, vgaColour}, held);
                end
            end
            if (plotReady) begin
                acc_count++;
                held_v = 1'b0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d expected none",
                             vgaX, vgaY, vgaColour);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(vgaX) != mon_e.x || int'(vgaY) != mon_e.y ||
                        int'(vgaColour) != mon_e.c) begin
                        bad++;
                        $display("FAIL pixel %0d: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                                 acc_count, vgaX, vgaY, vgaColour, mon_e.x, mon_e.y, mon_e.c);
                    end
                end
            end else begin
                held   = {vgaX, vgaY, vgaColour};
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
        if (frameDone) begin
            fd_count++;
            chk("busy_low_at_frame_done", int'(busy), 0);
        end
    end

    task automatic model_load();
        for (int c = 3; c > 0; c--) colv[c] = colv[c-1];
        colv[0] = (step_m < 115) ? song_fn(step_m) : 3'b000;
        step_m++;
    endtask

    task automatic push_frame();
        pix_t e;
        logic [2:0] cv;
        for (int lane = 0; lane < 3; lane++)
            for (int col = 0; col < 4; col++)
                for (int py = 0; py < 60; py++)
                    for (int px = 0; px < 30; px++) begin
                        cv  = colv[col];
                        e.x = col * 30 + px;
                        e.y = 60 + lane * 60 + py;
                        e.c = cv[lane] ? int'(spr_fn(py * 30 + px)) : 7;
                        exp_q.push_back(e);
                    end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int fd0;
        int n;
        fd0 = fd_count;
        n = 0;
        while (fd_count == fd0 && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (5) begin @(posedge clock); #1; end
        chk("frame_done_count", fd_count - fd0, 1);
    endtask

    initial begin
        int base, lat, n, fd0, seen;
        logic [2:0] exp_strike [6];
        exp_strike[0] = 3'b000; exp_strike[1] = 3'b000; exp_strike[2] = 3'b000;
        exp_strike[3] = 3'b001; exp_strike[4] = 3'b010; exp_strike[5] = 3'b000;
        reset = 1'b1; start = 1'b0; restart = 1'b0; start2 = 1'b0;
        for (int c = 0; c < 4; c++) colv[c] = 3'b000;
        step_m = 0;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_plot", int'(plot), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_song_done", int'(songDone), 0);
        chk("reset_strike", int'(strikeNotes), 0);
        chk("reset_vga_x", int'(vgaX), 0);
        chk("reset_vga_y", int'(vgaY), 0);
        chk("reset_colour", int'(vgaColour), 0);
        chk("reset_frame_done", int'(frameDone), 0);
        chk("reset_song_addr", int'(songAddr), 0);
        chk("reset_small_busy", int'(busy2), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Frame 1: full-speed accept, latency and full pixel count.
        model_load();
        push_frame();
        base = acc_count;
        pulse_start();
        lat = 0;
        while (!plot && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("first_plot_latency", lat, 4);
        chk("first_plot_colour", int'(vgaColour), 2);
        wait_done(30000);
        chk("frame1_pixels", acc_count - base, 21600);
        chk("frame1_queue_empty", exp_q.size(), 0);
        chk("frame1_song_done", int'(songDone), 0);

        // Frame 2: random backpressure.
        bp_mode = 1'b1;
        model_load();
        push_frame();
        base = acc_count;
        pulse_start();
        wait_done(90000);
        bp_mode = 1'b0;
        @(posedge clock); #1;
        chk("frame2_pixels", acc_count - base, 21600);
        chk("frame2_queue_empty", exp_q.size(), 0);

        // Frame 3: restart after 5000 pixels.
        model_load();
        push_frame();
        base = acc_count;
        pulse_start();
        n = 0;
        while (acc_count - base < 5000 && n < 20000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("restart_point_reached", (acc_count - base >= 5000) ? 1 : 0, 1);
        fd0 = fd_count;
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        chk("restart_plot", int'(plot), 0);
        chk("restart_busy", int'(busy), 0);
        chk("restart_frame_done", int'(frameDone), 0);
        chk("restart_strike", int'(strikeNotes), 0);
        exp_q.delete();
        repeat (30) begin @(posedge clock); #1; end
        chk("restart_no_frame_done", fd_count - fd0, 0);
        chk("restart_plot_still_low", int'(plot), 0);
        pulse_start();
        chk("restart_song_addr", int'(songAddr), 0);
        chk("restart_then_busy", int'(busy), 1);
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        chk("abort_no_frame_done", fd_count - fd0, 0);
        chk("abort_plot", int'(plot), 0);

        // Small instance: scroll to the strike column and run off the song.
        for (int f = 0; f < 6; f++) begin
            start2 = 1'b1;
            @(posedge clock); #1;
            start2 = 1'b0;
            @(posedge clock); #1;
            @(posedge clock); #1;
            chk($sformatf("strike_after_load%0d", f + 1), int'(strikeNotes2), int'(exp_strike[f]));
            chk($sformatf("song_done_after_load%0d", f + 1), int'(songDone2), (f == 5) ? 1 : 0);
            seen = 0;
            n = 0;
            while (seen == 0 && n < 1000) begin
                @(posedge clock); #1;
                n++;
                if (frameDone2) seen = 1;
            end
            chk($sformatf("small_frame%0d_done", f + 1), seen, 1);
            @(posedge clock); #1;
        end
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        chk("start_after_song_done_busy", int'(busy2), 0);
        seen = 0;
        repeat (200) begin
            @(posedge clock); #1;
            if (frameDone2 || plot2) seen++;
        end
        chk("start_after_song_done_ignored", seen, 0);
        chk("song_done_sticky", int'(songDone2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
